tl_inflight_monitor: RTL and testbench

Parametrised TileLink-UL/UH channel A/D protocol checker for the core's memory-side ports; a successor to the single-cycle opcode-exclusivity assertion wrappers.
- Adds sequential checks: per-source in-flight tracking, multi-beat burst counting and valid/payload stability.
- Sits passively beside a TL link, is never in the data path, and reports sticky error flags plus an error count.
- Synthesizable, so it can run on FPGA builds as well as in simulation.

---
 rtl/tl_mon_pkg.sv | 28 ++
 rtl/tl_mon_beat_tracker.sv | 74 +++++++
 rtl/tl_inflight_monitor.sv | 123 ++++++++++++
 tb/tb_tl_inflight_monitor.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_mon_pkg.sv
// Shared TileLink opcodes, error-bit positions and the beats-per-message rule
// used by the in-flight monitor and its per-channel beat trackers.
package tl_mon_pkg;

  localparam logic [2:0] OP_A_PUT_FULL        = 3'd0;
  localparam logic [2:0] OP_A_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] OP_A_GET             = 3'd4;
  localparam logic [2:0] OP_D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] OP_D_ACCESS_ACK_DATA = 3'd1;

  localparam int unsigned ERR_A_UNSTABLE       = 0;
  localparam int unsigned ERR_D_UNSTABLE       = 1;
  localparam int unsigned ERR_A_BURST_MISMATCH = 2;
  localparam int unsigned ERR_D_BURST_MISMATCH = 3;
  localparam int unsigned ERR_A_BAD_OPCODE     = 4;
  localparam int unsigned ERR_SRC_REUSE        = 5;
  localparam int unsigned ERR_D_NO_REQ         = 6;
  localparam int unsigned ERR_WDOG             = 7;

  // Sizes beyond the largest supported burst are clamped so the beat counter cannot wrap.
  function automatic int unsigned beats(input int unsigned size, input logic has_data,
                                        input int unsigned beat_lg, input int unsigned max_lg);
    if (!has_data || size <= beat_lg) return 1;
    if (size - beat_lg >= max_lg) return 32'd1 << max_lg;
    return 32'd1 << (size - beat_lg);
  endfunction

endpackage

// File: rtl/tl_mon_beat_tracker.sv
// Per-channel burst position tracker plus valid/payload stability check; passive, never stalls.
// first/last/mismatch/unstable are combinational on the current inputs and the previous-cycle hold registers.
module tl_mon_beat_tracker
  import tl_mon_pkg::*;
#(
  parameter int unsigned SIZE_W        = 3,
  parameter int unsigned SRC_W         = 4,
  parameter int unsigned AUX_W         = 1,
  parameter int unsigned BEAT_BYTES_LG = 3,
  parameter int unsigned MAX_BEATS_LG  = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fire,
  input  logic              valid,
  input  logic              ready,
  input  logic [2:0]        opcode,
  input  logic [SIZE_W-1:0] size,
  input  logic [SRC_W-1:0]  source,
  input  logic [AUX_W-1:0]  aux,
  input  logic              has_data,
  output logic              first,
  output logic              last,
  output logic              mismatch,
  output logic              unstable
);

  localparam int unsigned FLD_W  = 3 + SIZE_W + SRC_W + AUX_W;
  localparam int unsigned BCNT_W = MAX_BEATS_LG + 1;

  logic [MAX_BEATS_LG-1:0] remaining;
  logic [2:0]              hold_op;
  logic [SIZE_W-1:0]       hold_size;
  logic [SRC_W-1:0]        hold_src;
  logic                    prev_stall;
  logic [FLD_W-1:0]        prev_fld;
  logic [FLD_W-1:0]        fld;
  logic [BCNT_W-1:0]       nbeats;

  assign fld    = {opcode, size, source, aux};
  assign nbeats = BCNT_W'(beats(32'(size), has_data, BEAT_BYTES_LG, MAX_BEATS_LG));

  // remaining == 0 means no burst is open, so the next fire starts one.
  assign first    = (remaining == '0);
  assign last     = first ? (nbeats == BCNT_W'(1)) : (remaining == MAX_BEATS_LG'(1));
  assign mismatch = fire & ~first &
                    ((opcode != hold_op) | (size != hold_size) | (source != hold_src));
  assign unstable = prev_stall & (~valid | (fld != prev_fld));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      remaining  <= '0;
      hold_op    <= '0;
      hold_size  <= '0;
      hold_src   <= '0;
      prev_stall <= 1'b0;
      prev_fld   <= '0;
    end else begin
      prev_stall <= valid & ~ready;
      prev_fld   <= fld;
      if (fire) begin
        if (first) begin
          remaining <= MAX_BEATS_LG'(nbeats - 1'b1);
          hold_op   <= opcode;
          hold_size <= size;
          hold_src  <= source;
        end else begin
          remaining <= remaining - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tl_inflight_monitor.sv
// Passive TileLink-UL/UH A/D checker: sticky error flags one cycle after detection, never backpressures.
// Optional response watchdog compiled in with TLMON_WATCHDOG_EN.
module tl_inflight_monitor
  import tl_mon_pkg::*;
#(
  parameter int unsigned SRC_W         = 4,
  parameter int unsigned SIZE_W        = 3,
  parameter int unsigned BEAT_BYTES_LG = 3,
  parameter int unsigned MAX_BEATS_LG  = 3,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned WDOG_W        = 12,
  localparam int unsigned NSRC         = 2 ** SRC_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_valid,
  input  logic              a_ready,
  input  logic [2:0]        a_opcode,
  input  logic [SIZE_W-1:0] a_size,
  input  logic [SRC_W-1:0]  a_source,
  input  logic [29:0]       a_address,
  input  logic              d_valid,
  input  logic              d_ready,
  input  logic [2:0]        d_opcode,
  input  logic [SIZE_W-1:0] d_size,
  input  logic [SRC_W-1:0]  d_source,
  output logic [7:0]        err_flags,
  output logic [CNT_W-1:0]  err_count,
  output logic [NSRC-1:0]   inflight,
  output logic              busy
);

  logic a_fire, d_fire;
  logic a_first, a_last, a_mismatch, a_unstable;
  logic d_first, d_last, d_mismatch, d_unstable;
  logic a_has_data, d_has_data;
  logic a_bad;
  logic wdog_det;
  logic [7:0]      det;
  logic [NSRC-1:0] inf_set, inf_clr;

  assign a_fire     = a_valid & a_ready;
  assign d_fire     = d_valid & d_ready;
  assign a_has_data = (a_opcode == OP_A_PUT_FULL) | (a_opcode == OP_A_PUT_PARTIAL);
  assign d_has_data = (d_opcode == OP_D_ACCESS_ACK_DATA);
  assign busy       = |inflight;

  tl_mon_beat_tracker #(
    .SIZE_W(SIZE_W), .SRC_W(SRC_W), .AUX_W(30),
    .BEAT_BYTES_LG(BEAT_BYTES_LG), .MAX_BEATS_LG(MAX_BEATS_LG)
  ) u_a_track (
    .clock(clock), .reset_n(reset_n), .fire(a_fire), .valid(a_valid), .ready(a_ready),
    .opcode(a_opcode), .size(a_size), .source(a_source), .aux(a_address),
    .has_data(a_has_data), .first(a_first), .last(a_last),
    .mismatch(a_mismatch), .unstable(a_unstable)
  );

  tl_mon_beat_tracker #(
    .SIZE_W(SIZE_W), .SRC_W(SRC_W), .AUX_W(1),
    .BEAT_BYTES_LG(BEAT_BYTES_LG), .MAX_BEATS_LG(MAX_BEATS_LG)
  ) u_d_track (
    .clock(clock), .reset_n(reset_n), .fire(d_fire), .valid(d_valid), .ready(d_ready),
    .opcode(d_opcode), .size(d_size), .source(d_source), .aux(1'b0),
    .has_data(d_has_data), .first(d_first), .last(d_last),
    .mismatch(d_mismatch), .unstable(d_unstable)
  );

  assign a_bad = a_valid &
                 (((a_opcode != OP_A_PUT_FULL) & (a_opcode != OP_A_PUT_PARTIAL) &
                   (a_opcode != OP_A_GET)) |
                  ((a_address & ((30'd1 << a_size) - 30'd1)) != '0));

  assign inf_set = (a_fire & a_first) ? (NSRC'(1) << a_source) : '0;
  assign inf_clr = (d_fire & d_last)  ? (NSRC'(1) << d_source) : '0;

  always_comb begin
    det = '0;
    det[ERR_A_UNSTABLE]       = a_unstable;
    det[ERR_D_UNSTABLE]       = d_unstable;
    det[ERR_A_BURST_MISMATCH] = a_mismatch;
    det[ERR_D_BURST_MISMATCH] = d_mismatch;
    det[ERR_A_BAD_OPCODE]     = a_bad;
    // A retiring response to the same source in this cycle frees the ID for reuse.
    det[ERR_SRC_REUSE]        = a_fire & a_first & inflight[a_source] &
                                ~(d_fire & d_last & (d_source == a_source));
    det[ERR_D_NO_REQ]         = d_fire & d_first & ~inflight[d_source];
    det[ERR_WDOG]             = wdog_det;
  end

`ifdef TLMON_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog;

  // Fires on the step into all-ones only; the counter then parks until a response.
  assign wdog_det = busy & ~d_fire & (wdog == ~WDOG_W'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wdog <= '0;
    end else if (d_fire || !busy) begin
      wdog <= '0;
    end else if (wdog != {WDOG_W{1'b1}}) begin
      wdog <= wdog + 1'b1;
    end
  end
`else
  assign wdog_det = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_flags <= '0;
      err_count <= '0;
      inflight  <= '0;
    end else begin
      err_flags <= err_flags | det;
      if ((|det) && (err_count != {CNT_W{1'b1}})) begin
        err_count <= err_count + 1'b1;
      end
      inflight <= (inflight & ~inf_clr) | inf_set;
    end
  end

endmodule

// File: tb/tb_tl_inflight_monitor.sv
// Self-checking bench for tl_inflight_monitor: directed scenarios plus random legal traffic
// checked against a transaction-level scoreboard of outstanding sources and expected errors.
module tb_tl_inflight_monitor;
  import tl_mon_pkg::*;

`ifdef TLMON_WATCHDOG_EN
  localparam int unsigned WDOG_W = 4;
`else
  localparam int unsigned WDOG_W = 12;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        a_valid, a_ready, d_valid, d_ready;
  logic [2:0]  a_opcode, a_size, d_opcode, d_size;
  logic [3:0]  a_source, d_source;
  logic [29:0] a_address;
  logic [7:0]  err_flags;
  logic [15:0] err_count;
  logic [15:0] inflight;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0]  exp_flags = '0;
  logic [15:0] exp_count = '0;

  always #5 clock = ~clock;

  tl_inflight_monitor #(
    .SRC_W(4), .SIZE_W(3), .BEAT_BYTES_LG(3), .MAX_BEATS_LG(3), .CNT_W(16), .WDOG_W(WDOG_W)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_source(a_source), .a_address(a_address),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source),
    .err_flags(err_flags), .err_count(err_count), .inflight(inflight), .busy(busy)
  );

  task automatic idle();
    a_valid = 0; a_ready = 1; a_opcode = '0; a_size = '0; a_source = '0; a_address = '0;
    d_valid = 0; d_ready = 1; d_opcode = '0; d_size = '0; d_source = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int nbeats(input logic has_data, input logic [2:0] size);
    return (has_data && int'(size) > 3) ? (1 << (int'(size) - 3)) : 1;
  endfunction

  task automatic send_a(input logic [2:0] op, input logic [2:0] size, input logic [3:0] src,
                        input logic [29:0] addr, input int stall);
    int nb;
    nb = nbeats(op == OP_A_PUT_FULL || op == OP_A_PUT_PARTIAL, size);
    a_valid = 1; a_opcode = op; a_size = size; a_source = src; a_address = addr;
    if (stall > 0) begin
      a_ready = 0;
      repeat (stall) tick();
    end
    a_ready = 1;
    for (int b = 0; b < nb; b++) tick();
    a_valid = 0;
  endtask

  task automatic send_d(input logic [2:0] op, input logic [2:0] size, input logic [3:0] src,
                        input int stall);
    int nb;
    nb = nbeats(op == OP_D_ACCESS_ACK_DATA, size);
    d_valid = 1; d_opcode = op; d_size = size; d_source = src;
    if (stall > 0) begin
      d_ready = 0;
      repeat (stall) tick();
    end
    d_ready = 1;
    for (int b = 0; b < nb; b++) tick();
    d_valid = 0;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 0;
    #12;
    n_checks++; if (err_flags !== 8'h00) begin n_fail++; $display("FAIL reset_flags: got %h want 00", err_flags); end
    n_checks++; if (err_count !== 16'h0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", err_count); end
    n_checks++; if (inflight !== 16'h0) begin n_fail++; $display("FAIL reset_inflight: got %h want 0000", inflight); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    tick();
    reset_n = 1;
    tick();
  endtask

  task automatic test_single_get();
    send_a(OP_A_GET, 3'd3, 4'd2, 30'h100, 0);
    n_checks++; if (inflight !== 16'h0004) begin n_fail++; $display("FAIL get_inflight: got %h want 0004", inflight); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL get_busy: got %b want 1", busy); end
    send_d(OP_D_ACCESS_ACK_DATA, 3'd3, 4'd2, 0);
    n_checks++; if (inflight !== 16'h0000) begin n_fail++; $display("FAIL ack_inflight: got %h want 0000", inflight); end
    n_checks++; if (err_flags !== 8'h00) begin n_fail++; $display("FAIL get_flags: got %h want 00", err_flags); end
    n_checks++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL get_count: got %0d want 0", err_count); end
  endtask

  task automatic test_burst_mismatch();
    for (int b = 0; b < 4; b++) begin
      a_valid = 1; a_ready = 1; a_opcode = OP_A_PUT_FULL; a_size = 3'd5; a_address = 30'h40;
      a_source = (b == 2) ? 4'd1 : 4'd0;
      tick();
      if (b == 2) begin
        exp_flags |= 8'h01 << ERR_A_BURST_MISMATCH;
        exp_count++;
        n_checks++; if (err_flags !== exp_flags) begin n_fail++; $display("FAIL burst_flags: got %h want %h", err_flags, exp_flags); end
        n_checks++; if (err_count !== exp_count) begin n_fail++; $display("FAIL burst_count: got %0d want %0d", err_count, exp_count); end
      end
    end
    a_valid = 0;
    n_checks++; if (inflight !== 16'h0001) begin n_fail++; $display("FAIL burst_inflight: got %h want 0001", inflight); end
    send_d(OP_D_ACCESS_ACK, 3'd5, 4'd0, 0);
    n_checks++; if (inflight !== 16'h0000) begin n_fail++; $display("FAIL burst_retire: got %h want 0000", inflight); end
    n_checks++; if (err_count !== exp_count) begin n_fail++; $display("FAIL burst_count_end: got %0d want %0d", err_count, exp_count); end
  endtask

  task automatic test_unstable();
    a_valid = 1; a_ready = 0; a_opcode = OP_A_GET; a_size = 3'd2; a_source = 4'd5; a_address = 30'h200;
    tick();
    n_checks++; if (err_flags !== exp_flags) begin n_fail++; $display("FAIL stall_ok: got %h want %h", err_flags, exp_flags); end
    a_address = 30'h204;
    tick();
    exp_flags |= 8'h01 << ERR_A_UNSTABLE;
    exp_count++;
    n_checks++; if (err_flags !== exp_flags) begin n_fail++; $display("FAIL unstable_flag: got %h want %h", err_flags, exp_flags); end
    n_checks++; if (err_count !== exp_count) begin n_fail++; $display("FAIL unstable_count1: got %0d want %0d", err_count, exp_count); end
    tick();
    n_checks++; if (err_count !== exp_count) begin n_fail++; $display("FAIL unstable_hold: got %0d want %0d", err_count, exp_count); end
    a_address = 30'h200;
    tick();
    exp_count++;
    n_checks++; if (err_count !== exp_count) begin n_fail++; $display("FAIL unstable_count2: got %0d want %0d", err_count, exp_count); end
    n_checks++; if (err_flags !== exp_flags) begin n_fail++; $display("FAIL unstable_sticky: got %h want %h", err_flags, exp_flags); end
    a_ready = 1;
    tick();
    a_valid = 0;
    n_checks++; if (inflight !== 16'h0020) begin n_fail++; $display("FAIL unstable_fire: got %h want 0020", inflight); end
    send_d(OP_D_ACCESS_ACK_DATA, 3'd2, 4'd5, 0);
    n_checks++; if (err_count !== exp_count) begin n_fail++; $display("FAIL unstable_end: got %0d want %0d", err_count, exp_count); end
  endtask

  task automatic test_d_no_req_and_retire();
    send_d(OP_D_ACCESS_ACK, 3'd0, 4'd7, 0);
    exp_flags |= 8'h01 << ERR_D_NO_REQ;
    exp_count++;
    n_checks++; if (err_flags !== exp_flags) begin n_fail++; $display("FAIL noreq_flag: got %h want %h", err_flags, exp_flags); end
    n_checks++; if (inflight !== 16'h0000) begin n_fail++; $display("FAIL noreq_inflight: got %h want 0000", inflight); end
    send_a(OP_A_PUT_FULL, 3'd3, 4'd3, 30'h300, 0);
    a_valid = 1; a_ready = 1; a_opcode = OP_A_GET; a_size = 3'd3; a_source = 4'd3; a_address = 30'h308;
    d_valid = 1; d_ready = 1; d_opcode = OP_D_ACCESS_ACK; d_size = 3'd3; d_source = 4'd3;
    tick();
    a_valid = 0; d_valid = 0;
    n_checks++; if (inflight !== 16'h0008) begin n_fail++; $display("FAIL reuse_inflight: got %h want 0008", inflight); end
    n_checks++; if (err_flags !== exp_flags) begin n_fail++; $display("FAIL reuse_flags: got %h want %h", err_flags, exp_flags); end
    n_checks++; if (err_count !== exp_count) begin n_fail++; $display("FAIL reuse_count: got %0d want %0d", err_count, exp_count); end
    send_d(OP_D_ACCESS_ACK_DATA, 3'd3, 4'd3, 0);
    n_checks++; if (inflight !== 16'h0000) begin n_fail++; $display("FAIL reuse_retire: got %h want 0000", inflight); end
  endtask

  task automatic test_watchdog();
    int hit;
    hit = -1;
    send_a(OP_A_GET, 3'd3, 4'd9, 30'h900, 0);
`ifdef TLMON_WATCHDOG_EN
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (hit < 0 && err_flags[ERR_WDOG] === 1'b1) hit = i;
    end
    exp_flags |= 8'h01 << ERR_WDOG;
    exp_count++;
    n_checks++; if (hit !== 15) begin n_fail++; $display("FAIL wdog_cycle: got %0d want 15", hit); end
`else
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (hit < 0 && err_flags[ERR_WDOG] !== 1'b0) hit = i;
    end
    n_checks++; if (hit !== -1) begin n_fail++; $display("FAIL wdog_absent: bit7 set at cycle %0d want never", hit); end
`endif
    n_checks++; if (err_flags !== exp_flags) begin n_fail++; $display("FAIL wdog_flags: got %h want %h", err_flags, exp_flags); end
    n_checks++; if (err_count !== exp_count) begin n_fail++; $display("FAIL wdog_count: got %0d want %0d", err_count, exp_count); end
    send_d(OP_D_ACCESS_ACK_DATA, 3'd3, 4'd9, 0);
    n_checks++; if (inflight !== 16'h0000) begin n_fail++; $display("FAIL wdog_retire: got %h want 0000", inflight); end
  endtask

  task automatic test_reset_mid_burst();
    a_valid = 1; a_ready = 1; a_opcode = OP_A_PUT_FULL; a_size = 3'd5; a_source = 4'd4; a_address = 30'h80;
    tick();
    #2;
    reset_n = 0;
    #1;
    n_checks++; if (err_flags !== 8'h00) begin n_fail++; $display("FAIL rst_flags: got %h want 00", err_flags); end
    n_checks++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", err_count); end
    n_checks++; if (inflight !== 16'h0000) begin n_fail++; $display("FAIL rst_inflight: got %h want 0000", inflight); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    idle();
    tick();
    reset_n = 1;
    exp_flags = '0;
    exp_count = '0;
    tick();
    send_a(OP_A_GET, 3'd3, 4'd4, 30'h80, 0);
    n_checks++; if (inflight !== 16'h0010) begin n_fail++; $display("FAIL post_rst_get: got %h want 0010", inflight); end
    send_d(OP_D_ACCESS_ACK_DATA, 3'd3, 4'd4, 0);
    n_checks++; if (err_flags !== 8'h00) begin n_fail++; $display("FAIL post_rst_flags: got %h want 00", err_flags); end
    n_checks++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL post_rst_count: got %0d want 0", err_count); end
  endtask

  task automatic test_random();
    logic [2:0]  req_op [16];
    logic [2:0]  req_size [16];
    logic [15:0] model;
    int          pend[$];
    int          nreq, src, idx;
    logic [2:0]  op, size;
    logic [29:0] addr;
    model = '0;
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        a_valid = 1; a_ready = 0; a_source = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 0) begin
          a_opcode = 3'($urandom_range(5, 7)); a_size = 3'd0; a_address = 30'h10;
        end else begin
          a_opcode = OP_A_GET; a_size = 3'd3; a_address = 30'h11;
        end
        tick();
        a_valid = 0; a_ready = 1;
        tick();
        exp_flags |= (8'h01 << ERR_A_BAD_OPCODE) | (8'h01 << ERR_A_UNSTABLE);
        exp_count += 16'd2;
        n_checks++; if (err_flags !== exp_flags) begin n_fail++; $display("FAIL rnd_bad_flags it%0d: got %h want %h", it, err_flags, exp_flags); end
      end
      nreq = $urandom_range(1, 2);
      for (int k = 0; k < nreq; k++) begin
        do src = $urandom_range(0, 15); while (model[src]);
        case ($urandom_range(0, 2))
          0: op = OP_A_PUT_FULL;
          1: op = OP_A_PUT_PARTIAL;
          default: op = OP_A_GET;
        endcase
        size = 3'($urandom_range(0, 5));
        addr = 30'($urandom) & ~((30'd1 << size) - 30'd1);
        send_a(op, size, 4'(src), addr, $urandom_range(0, 1));
        req_op[src] = op; req_size[src] = size; model[src] = 1'b1;
        pend.push_back(src);
        n_checks++; if (inflight !== model) begin n_fail++; $display("FAIL rnd_issue it%0d: got %h want %h", it, inflight, model); end
      end
      while (pend.size() > 0) begin
        idx = $urandom_range(0, pend.size() - 1);
        src = pend[idx];
        pend.delete(idx);
        send_d((req_op[src] == OP_A_GET) ? OP_D_ACCESS_ACK_DATA : OP_D_ACCESS_ACK,
               req_size[src], 4'(src), $urandom_range(0, 1));
        model[src] = 1'b0;
        n_checks++; if (inflight !== model) begin n_fail++; $display("FAIL rnd_retire it%0d: got %h want %h", it, inflight, model); end
      end
      n_checks++; if (err_flags !== exp_flags) begin n_fail++; $display("FAIL rnd_flags it%0d: got %h want %h", it, err_flags, exp_flags); end
      n_checks++; if (err_count !== exp_count) begin n_fail++; $display("FAIL rnd_count it%0d: got %0d want %0d", it, err_count, exp_count); end
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_get();
    test_burst_mismatch();
    test_unstable();
    test_d_no_req_and_retire();
    test_watchdog();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
